// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
// Round-robin front end that lets two requesters share one signed WIDTH x WIDTH
// multiplier core. It registers the winning operand pair onto the core inputs,
// carries an ownership tag alongside the core's LAT pipeline stages, and returns
// each product to its issuer as a one-cycle result pulse.

module mult_share_arbiter #(
   parameter int WIDTH = 16,
   parameter int LAT   = 0
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [WIDTH-1:0]     req0_a,
   input  logic [WIDTH-1:0]     req0_b,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [WIDTH-1:0]     req1_a,
   input  logic [WIDTH-1:0]     req1_b,
   output logic [WIDTH-1:0]     mult_a,
   output logic [WIDTH-1:0]     mult_b,
   input  logic [2*WIDTH-1:0]   mult_p,
   output logic [2*WIDTH-1:0]   res_p,
   output logic                 res0_valid,
   output logic                 res1_valid,
   output logic                 busy
);

   logic           rr;
   logic           grant;
   logic           grant_id;
   logic [LAT:0]   tag_vld;
   logic [LAT:0]   tag_id;
   logic [LAT:0]   next_tag_vld;
   logic [LAT:0]   next_tag_id;

   // Round-robin grant: a lone requester always wins, a tie goes to whoever rr points at.
   always_comb begin
      req0_ready = req0_valid && (!req1_valid || !rr);
      req1_ready = req1_valid && (!req0_valid || rr);
      grant      = req0_ready || req1_ready;
      grant_id   = req1_ready;
   end

   // Next state of the ownership tags: stage 0 takes this cycle's grant, the rest shift along.
   always_comb begin
      next_tag_vld    = '0;
      next_tag_id     = '0;
      next_tag_vld[0] = grant;
      next_tag_id[0]  = grant_id;
      for (int i = 1; i <= LAT; i++) begin
         next_tag_vld[i] = tag_vld[i-1];
         next_tag_id[i]  = tag_id[i-1];
      end
   end

   // Operand capture, priority rotation, tag shift and result return; reset discards all in-flight work.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rr         <= 1'b0;
         mult_a     <= '0;
         mult_b     <= '0;
         tag_vld    <= '0;
         tag_id     <= '0;
         res_p      <= '0;
         res0_valid <= 1'b0;
         res1_valid <= 1'b0;
         busy       <= 1'b0;
      end else begin
         if (grant) begin
            mult_a <= grant_id ? req1_a : req0_a;
            mult_b <= grant_id ? req1_b : req0_b;
            rr     <= ~grant_id;
         end
         tag_vld    <= next_tag_vld;
         tag_id     <= next_tag_id;
         res0_valid <= tag_vld[LAT] && !tag_id[LAT];
         res1_valid <= tag_vld[LAT] && tag_id[LAT];
         if (tag_vld[LAT]) begin
            res_p <= mult_p;
         end
         busy <= (|next_tag_vld) || tag_vld[LAT];
      end
   end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter
// Drives two instances (combinational core and 3-stage core) with the same
// requests and compares them to a cycle-indexed record of accepted operations.

module tb_mult_share_arbiter;

   localparam int W    = 16;
   localparam int MAXC = 4096;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic v0 = 1'b0;
   logic v1 = 1'b0;
   logic [W-1:0] a0 = '0;
   logic [W-1:0] b0 = '0;
   logic [W-1:0] a1 = '0;
   logic [W-1:0] b1 = '0;

   logic [1:0]          rdy0, rdy1, rv0, rv1, bsy;
   logic [1:0][W-1:0]   ma, mb;
   logic [1:0][2*W-1:0] mp, rp;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Reference record: what was accepted in each cycle and what it should produce.
   logic          acc_vld [MAXC];
   logic          acc_id  [MAXC];
   logic [31:0]   acc_p   [MAXC];
   logic          m_rr;
   logic [W-1:0]  exp_a, exp_b;
   logic [31:0]   last_res [2];
   int            lat_of [2];

   logic [31:0]   pipe3 [3];

   always #5 clk = ~clk;

   // Cycle index advances at every rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   mult_share_arbiter #(.WIDTH(W), .LAT(0)) dut_l0 (
      .sys_clk(clk), .sys_rst_n(rst_n),
      .req0_valid(v0), .req0_ready(rdy0[0]), .req0_a(a0), .req0_b(b0),
      .req1_valid(v1), .req1_ready(rdy1[0]), .req1_a(a1), .req1_b(b1),
      .mult_a(ma[0]), .mult_b(mb[0]), .mult_p(mp[0]),
      .res_p(rp[0]), .res0_valid(rv0[0]), .res1_valid(rv1[0]), .busy(bsy[0])
   );

   mult_share_arbiter #(.WIDTH(W), .LAT(3)) dut_l3 (
      .sys_clk(clk), .sys_rst_n(rst_n),
      .req0_valid(v0), .req0_ready(rdy0[1]), .req0_a(a0), .req0_b(b0),
      .req1_valid(v1), .req1_ready(rdy1[1]), .req1_a(a1), .req1_b(b1),
      .mult_a(ma[1]), .mult_b(mb[1]), .mult_p(mp[1]),
      .res_p(rp[1]), .res0_valid(rv0[1]), .res1_valid(rv1[1]), .busy(bsy[1])
   );

   // Combinational core model for the LAT=0 instance.
   assign mp[0] = $signed({{W{ma[0][W-1]}}, ma[0]}) * $signed({{W{mb[0][W-1]}}, mb[0]});

   // Three-stage core model for the LAT=3 instance.
   always @(posedge clk) begin
      pipe3[0] <= $signed({{W{ma[1][W-1]}}, ma[1]}) * $signed({{W{mb[1][W-1]}}, mb[1]});
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end
   assign mp[1] = pipe3[2];

   function automatic logic [31:0] refProduct(input logic [W-1:0] x, input logic [W-1:0] y);
      int sx, sy;
      sx = $signed(x);
      sy = $signed(y);
      return 32'(sx * sy);
   endfunction

   function automatic logic [W-1:0] pickOperand();
      case ($urandom_range(0, 4))
         0: return 16'h8000;
         1: return 16'h7FFF;
         2: return 16'hFFFF;
         default: return W'($urandom());
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s at cycle %0d: observed %h, expected %h", tag, cyc, obs, exp);
      end
   endtask

   // Registered outputs of instance d in the current cycle against the record.
   task automatic checkDut(input int d);
      int s;
      logic e0, e1, eb;
      string n;
      n  = $sformatf("L%0d", lat_of[d]);
      e0 = 1'b0;
      e1 = 1'b0;
      eb = 1'b0;
      s  = cyc - lat_of[d] - 2;
      if (s >= 0 && acc_vld[s]) begin
         e0 = !acc_id[s];
         e1 = acc_id[s];
         last_res[d] = acc_p[s];
      end
      for (int k = cyc - lat_of[d] - 2; k < cyc; k++)
         if (k >= 0 && acc_vld[k]) eb = 1'b1;
      checkOutput({n, " res0_valid"}, 32'(rv0[d]), 32'(e0));
      checkOutput({n, " res1_valid"}, 32'(rv1[d]), 32'(e1));
      checkOutput({n, " res_p"}, rp[d], last_res[d]);
      checkOutput({n, " busy"}, 32'(bsy[d]), 32'(eb));
      checkOutput({n, " mult_a"}, 32'(ma[d]), 32'(exp_a));
      checkOutput({n, " mult_b"}, 32'(mb[d]), 32'(exp_b));
   endtask

   // One cycle of requests: drive, check, then record what the arbiter should accept.
   task automatic applyStimulus(input logic iv0, input logic [W-1:0] ia0, input logic [W-1:0] ib0,
                                input logic iv1, input logic [W-1:0] ia1, input logic [W-1:0] ib1);
      logic g0, g1;
      @(negedge clk);
      if (cyc >= MAXC) begin
         $display("[TB] FAIL cycle_budget: observed %0d cycles, limit %0d", cyc, MAXC);
         $fatal(1, "[TB] cycle budget exceeded");
      end
      v0 = iv0; a0 = ia0; b0 = ib0;
      v1 = iv1; a1 = ia1; b1 = ib1;
      #1;
      checkDut(0);
      checkDut(1);
      g0 = iv0 && (!iv1 || m_rr == 1'b0);
      g1 = iv1 && (!iv0 || m_rr == 1'b1);
      for (int d = 0; d < 2; d++) begin
         checkOutput($sformatf("L%0d req0_ready", lat_of[d]), 32'(rdy0[d]), 32'(g0));
         checkOutput($sformatf("L%0d req1_ready", lat_of[d]), 32'(rdy1[d]), 32'(g1));
      end
      acc_vld[cyc] = g0 || g1;
      acc_id[cyc]  = g1;
      acc_p[cyc]   = g1 ? refProduct(ia1, ib1) : refProduct(ia0, ib0);
      // The requester that lost a tie is preferred next time.
      if (g0) begin
         exp_a = ia0; exp_b = ib0; m_rr = 1'b1;
      end else if (g1) begin
         exp_a = ia1; exp_b = ib1; m_rr = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   // Mid-cycle asynchronous reset: outputs must clear at once and the record is wiped.
   task automatic doReset();
      @(negedge clk);
      v0 = 1'b0;
      v1 = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         checkOutput($sformatf("L%0d rst mult_a", lat_of[d]), 32'(ma[d]), 32'h0);
         checkOutput($sformatf("L%0d rst mult_b", lat_of[d]), 32'(mb[d]), 32'h0);
         checkOutput($sformatf("L%0d rst res_p", lat_of[d]), rp[d], 32'h0);
         checkOutput($sformatf("L%0d rst res0_valid", lat_of[d]), 32'(rv0[d]), 32'h0);
         checkOutput($sformatf("L%0d rst res1_valid", lat_of[d]), 32'(rv1[d]), 32'h0);
         checkOutput($sformatf("L%0d rst busy", lat_of[d]), 32'(bsy[d]), 32'h0);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < MAXC; i++) acc_vld[i] = 1'b0;
      m_rr = 1'b0;
      exp_a = '0;
      exp_b = '0;
      last_res[0] = '0;
      last_res[1] = '0;
   endtask

   initial begin
      lat_of[0] = 0;
      lat_of[1] = 3;
      for (int i = 0; i < MAXC; i++) begin
         acc_vld[i] = 1'b0;
         acc_id[i]  = 1'b0;
         acc_p[i]   = '0;
      end
      m_rr = 1'b0;
      exp_a = '0;
      exp_b = '0;
      last_res[0] = '0;
      last_res[1] = '0;

      // Lone requester 0: -3 x 5.
      doReset();
      applyStimulus(1'b1, 16'hFFFD, 16'h0005, 1'b0, '0, '0);
      idle(2);
      checkOutput("t1 res_p", rp[0], 32'hFFFF_FFF1);
      checkOutput("t1 res0_valid", 32'(rv0[0]), 32'h1);
      idle(4);

      // Both requesting continuously: grants alternate.
      doReset();
      applyStimulus(1'b1, 16'h0002, 16'h0003, 1'b1, 16'hFFFF, 16'h0007);
      applyStimulus(1'b1, 16'h0002, 16'h0003, 1'b1, 16'hFFFF, 16'h0007);
      applyStimulus(1'b1, 16'h0010, 16'hFFF0, 1'b1, 16'h0100, 16'h0100);
      applyStimulus(1'b1, 16'h0010, 16'hFFF0, 1'b1, 16'h0100, 16'h0100);
      idle(6);

      // Requester 1 alone on the 3-stage core: max positive squared.
      applyStimulus(1'b0, '0, '0, 1'b1, 16'h7FFF, 16'h7FFF);
      idle(5);
      checkOutput("t3 res_p", rp[1], 32'h3FFF_0001);
      checkOutput("t3 res1_valid", 32'(rv1[1]), 32'h1);
      idle(1);
      checkOutput("t3 busy low", 32'(bsy[1]), 32'h0);

      // Reset one cycle after an issue: result lost, priority back to requester 0.
      applyStimulus(1'b1, 16'h8000, 16'h8000, 1'b0, '0, '0);
      doReset();
      idle(6);
      applyStimulus(1'b1, 16'h0001, 16'h0001, 1'b1, 16'h0002, 16'h0002);
      idle(5);

      // Requester 1 last, then requester 0 alone three times, then a tie.
      applyStimulus(1'b0, '0, '0, 1'b1, 16'h0005, 16'h0006);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'(i + 1), 16'hFFFE, 1'b0, '0, '0);
      applyStimulus(1'b1, 16'h0009, 16'h0009, 1'b1, 16'h000A, 16'h000A);
      checkOutput("t5 tie req1_ready", 32'(rdy1[0]), 32'h1);
      idle(5);

      // Idle hold after an issue of 3 x 4.
      applyStimulus(1'b1, 16'h0003, 16'h0004, 1'b0, '0, '0);
      idle(5);
      checkOutput("t6 mult_a held", 32'(ma[0]), 32'h3);
      checkOutput("t6 mult_b held", 32'(mb[0]), 32'h4);

      // Random traffic with one reset in the middle.
      for (int i = 0; i < 300; i++) begin
         if (i == 150) doReset();
         applyStimulus($urandom_range(0, 3) != 0, pickOperand(), pickOperand(),
                       $urandom_range(0, 2) != 0, pickOperand(), pickOperand());
      end
      idle(6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
